bcd_a_binario: RTL and testbench

// - Converts a packed two-digit BCD byte (tens in [7:4], units in [3:0]) to an unsigned binary count 0..MAX_VAL.
// - Inverse of the count-to-BCD display decoder; used when RTC registers or user-edited BCD fields are written back into the binary counters.
// - Two-stage pipeline with valid/ready handshake on both sides; flags non-BCD nibbles and out-of-range values.

---
 rtl/bcd_a_binario_pkg.sv | 35 +++
 rtl/bcd_a_binario_if.sv | 30 +++
 rtl/bcd_a_binario_etapa.sv | 51 +++++
 rtl/bcd_a_binario.sv | 87 ++++++++
 tb/tb_bcd_a_binario.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_a_binario_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_a_binario_pkg : shared constants and helpers for BCD-to-binary   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package bcd_a_binario_pkg;

  localparam int BCD_DIG_W   = 4;
  localparam int MAX_MIN_SEG = 59;
  localparam int MAX_HORA    = 23;
  localparam int BCD_DIG_MAX = 9;
  localparam int VALOR_W     = 7;

  typedef struct packed {
    logic [BCD_DIG_W-1:0] decenas;
    logic [BCD_DIG_W-1:0] unidades;
    logic                 dig_err;
  } e1_t;

  // tens*10 + units as two shifts and adds
  function automatic logic [VALOR_W-1:0] bcd_valor(input logic [BCD_DIG_W-1:0] d,
                                                   input logic [BCD_DIG_W-1:0] u);
    logic [VALOR_W-1:0] d7;
    logic [VALOR_W-1:0] u7;
    d7 = VALOR_W'(d);
    u7 = VALOR_W'(u);
    return (d7 << 3) + (d7 << 1) + u7;
  endfunction

  function automatic logic digito_malo(input logic [BCD_DIG_W-1:0] n);
    return n > BCD_DIG_W'(BCD_DIG_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_a_binario_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_a_binario_if : input/output handshake bundle of bcd_a_binario    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface bcd_a_binario_if
  import bcd_a_binario_pkg::*;
#(
  parameter int OUT_W = 6
);
  logic [2*BCD_DIG_W-1:0] bcd_entrada;
  logic                   valido_entrada;
  logic                   listo_entrada;
  logic [OUT_W-1:0]       binario_salida;
  logic                   error_salida;
  logic                   valido_salida;
  logic                   listo_salida;
  logic [7:0]             cuenta_errores;

  modport slave (
    input  bcd_entrada, valido_entrada, listo_salida,
    output listo_entrada, binario_salida, error_salida, valido_salida, cuenta_errores
  );

  modport master (
    output bcd_entrada, valido_entrada, listo_salida,
    input  listo_entrada, binario_salida, error_salida, valido_salida, cuenta_errores
  );
endinterface
`default_nettype wire

// File: rtl/bcd_a_binario_etapa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_a_binario_etapa : one valid/ready register slice, W data bits    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bcd_a_binario_etapa #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         valido_in,
  output logic         listo_in,
  input  logic [W-1:0] datos_in,
  output logic         valido_out,
  input  logic         listo_out,
  output logic [W-1:0] datos_out
);

  logic         valido_q;
  logic         valido_d;
  logic [W-1:0] datos_q;
  logic [W-1:0] datos_d;

  // Ready passes straight through from downstream so a full pipe still streams
  always_comb begin
    listo_in = !valido_q | listo_out;
    valido_d = valido_q;
    datos_d  = datos_q;
    if (listo_in) begin
      valido_d = valido_in;
      if (valido_in) begin
        datos_d = datos_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valido_q <= 1'b0;
      datos_q  <= '0;
    end else begin
      valido_q <= valido_d;
      datos_q  <= datos_d;
    end
  end

  assign valido_out = valido_q;
  assign datos_out  = datos_q;

endmodule
`default_nettype wire

// File: rtl/bcd_a_binario.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_a_binario : two-stage packed-BCD to binary converter with checks |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bcd_a_binario
  import bcd_a_binario_pkg::*;
#(
  parameter int MAX_VAL = MAX_MIN_SEG,
  parameter int OUT_W   = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  bcd_a_binario_if.slave  bus
);

  localparam int E1_W = $bits(e1_t);
  localparam int E2_W = OUT_W + 1;

  e1_t                e1_in;
  e1_t                e1_out;
  logic               v1;
  logic               avz2;
  logic [VALOR_W-1:0] valor;
  logic               error_conv;
  logic [E2_W-1:0]    e2_in;
  logic [E2_W-1:0]    e2_out;
  logic [7:0]         cuenta_q;
  logic [7:0]         cuenta_d;

  always_comb begin
    e1_in.decenas  = bus.bcd_entrada[2*BCD_DIG_W-1:BCD_DIG_W];
    e1_in.unidades = bus.bcd_entrada[BCD_DIG_W-1:0];
    e1_in.dig_err  = digito_malo(e1_in.decenas) | digito_malo(e1_in.unidades);
  end

  bcd_a_binario_etapa #(.W(E1_W)) u_e1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .valido_in  (bus.valido_entrada),
    .listo_in   (bus.listo_entrada),
    .datos_in   (e1_in),
    .valido_out (v1),
    .listo_out  (avz2),
    .datos_out  (e1_out)
  );

  // Bad digits can push valor past 7 bits; dig_err already marks those as errors
  always_comb begin
    valor      = bcd_valor(e1_out.decenas, e1_out.unidades);
    error_conv = e1_out.dig_err | (valor > VALOR_W'(MAX_VAL));
    e2_in      = {error_conv, (error_conv ? {OUT_W{1'b0}} : valor[OUT_W-1:0])};
  end

  bcd_a_binario_etapa #(.W(E2_W)) u_e2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .valido_in  (v1),
    .listo_in   (avz2),
    .datos_in   (e2_in),
    .valido_out (bus.valido_salida),
    .listo_out  (bus.listo_salida),
    .datos_out  (e2_out)
  );

  assign bus.error_salida   = e2_out[OUT_W];
  assign bus.binario_salida = e2_out[OUT_W-1:0];

  always_comb begin
    cuenta_d = cuenta_q;
    if (bus.valido_salida && bus.listo_salida && bus.error_salida && (cuenta_q != 8'hFF)) begin
      cuenta_d = cuenta_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cuenta_q <= 8'd0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign bus.cuenta_errores = cuenta_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_a_binario.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_a_binario : scoreboard bench for bcd_a_binario (59 and 23)    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bcd_a_binario;

  typedef struct {
    logic [5:0] bin;
    logic       err;
    int         t_acc;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_a_binario_if #(.OUT_W(6)) bus_a ();
  bcd_a_binario_if #(.OUT_W(5)) bus_b ();

  bcd_a_binario #(.MAX_VAL(59), .OUT_W(6)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  bcd_a_binario #(.MAX_VAL(23), .OUT_W(5)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [5:0] exp_bin_a = 6'd0;
  logic       exp_err_a = 1'b0;
  bit         lat_a = 1'b0;
  logic [5:0] exp_bin_b = 6'd0;
  logic       exp_err_b = 1'b0;
  bit         rand_phase = 1'b0;
  logic       listo_fixed = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #2;
    bus_a.listo_salida = rand_phase ? ($urandom_range(0, 2) != 0) : listo_fixed;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic void modelo(input logic [7:0] b, input int max_v,
                                 output logic [5:0] bin, output logic err);
    int t;
    int u;
    int v;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    v = t * 10 + u;
    err = (t > 9) || (u > 9) || (v > max_v);
    bin = err ? 6'd0 : v[5:0];
  endfunction

  // Scoreboard push on every accepted input
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb_a.delete();
      sb_b.delete();
    end else begin
      if (bus_a.valido_entrada && bus_a.listo_entrada) begin
        e.bin = exp_bin_a; e.err = exp_err_a; e.t_acc = cycle; e.lat = lat_a;
        sb_a.push_back(e);
      end
      if (bus_b.valido_entrada && bus_b.listo_entrada) begin
        e.bin = exp_bin_b; e.err = exp_err_b; e.t_acc = cycle; e.lat = 1'b1;
        sb_b.push_back(e);
      end
    end
  end

  // Monitors: pop and compare on every output transfer
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus_a.valido_salida && bus_a.listo_salida) begin
      if (sb_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: output %0d with nothing pending", bus_a.binario_salida);
      end else begin
        e = sb_a.pop_front();
        check("a_binario", 32'(bus_a.binario_salida), 32'(e.bin));
        check("a_error", 32'(bus_a.error_salida), 32'(e.err));
        if (e.lat) check("a_latency", 32'(cycle - e.t_acc), 32'd2);
      end
    end
    if (reset_n && bus_b.valido_salida && bus_b.listo_salida) begin
      if (sb_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: output %0d with nothing pending", bus_b.binario_salida);
      end else begin
        e = sb_b.pop_front();
        check("b_binario", 32'(bus_b.binario_salida), 32'(e.bin[4:0]));
        check("b_error", 32'(bus_b.error_salida), 32'(e.err));
        check("b_latency", 32'(cycle - e.t_acc), 32'd2);
      end
    end
  end

  task automatic wait_acc_a();
    int n = 0;
    @(negedge clk);
    while (!bus_a.listo_entrada && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: listo_entrada 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    bus_a.valido_entrada = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b, input logic [5:0] eb, input logic ee, input bit lat);
    bus_a.bcd_entrada = b;
    exp_bin_a = eb; exp_err_a = ee; lat_a = lat;
    bus_a.valido_entrada = 1'b1;
    wait_acc_a();
  endtask

  task automatic send_b(input logic [7:0] b, input logic [5:0] eb, input logic ee);
    bus_b.bcd_entrada = b;
    exp_bin_b = eb; exp_err_b = ee;
    bus_b.valido_entrada = 1'b1;
    @(posedge clk); #1;
    bus_b.valido_entrada = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d items pending, required 0", name, sb_a.size() + sb_b.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.valido_entrada = 1'b0; bus_a.bcd_entrada = 8'h00;
    bus_b.valido_entrada = 1'b0; bus_b.bcd_entrada = 8'h00;
    bus_b.listo_salida   = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valido", 32'(bus_a.valido_salida), 32'd0);
    check("rst_binario", 32'(bus_a.binario_salida), 32'd0);
    check("rst_error", 32'(bus_a.error_salida), 32'd0);
    check("rst_cuenta", 32'(bus_a.cuenta_errores), 32'd0);
    check("rst_b_valido", 32'(bus_b.valido_salida), 32'd0);
    reset_n = 1'b1;

    // Legal values with latency check
    send_a(8'h00, 6'd0, 1'b0, 1'b1);
    send_a(8'h07, 6'd7, 1'b0, 1'b1);
    send_a(8'h59, 6'd59, 1'b0, 1'b1);
    drain("drain_legal");

    // Out-of-range and non-BCD
    send_a(8'h60, 6'd0, 1'b1, 1'b1);
    send_a(8'h3A, 6'd0, 1'b1, 1'b1);
    send_a(8'hF0, 6'd0, 1'b1, 1'b1);
    drain("drain_err");
    check("cuenta_3", 32'(bus_a.cuenta_errores), 32'd3);

    // Backpressure: two items buffered, third blocked
    listo_fixed = 1'b0;
    send_a(8'h10, 6'd10, 1'b0, 1'b0);
    send_a(8'h11, 6'd11, 1'b0, 1'b0);
    bus_a.bcd_entrada = 8'h12; exp_bin_a = 6'd12; exp_err_a = 1'b0; lat_a = 1'b0;
    bus_a.valido_entrada = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_listo_entrada", 32'(bus_a.listo_entrada), 32'd0);
      check("stall_valido", 32'(bus_a.valido_salida), 32'd1);
      check("stall_binario", 32'(bus_a.binario_salida), 32'd10);
      check("stall_error", 32'(bus_a.error_salida), 32'd0);
    end
    @(posedge clk); #1;
    listo_fixed = 1'b1;
    wait_acc_a();
    drain("drain_stall");

    // Random handshake stream against the reference model
    rand_phase = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] b;
      logic [5:0] eb;
      logic       ee;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      modelo(b, 59, eb, ee);
      send_a(b, eb, ee, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        bus_a.bcd_entrada = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rand_phase = 1'b0;
    drain("drain_random");

    // Hours variant
    send_b(8'h23, 6'd23, 1'b0);
    send_b(8'h24, 6'd0, 1'b1);
    send_b(8'h09, 6'd9, 1'b0);
    drain("drain_b");
    check("b_cuenta", 32'(bus_b.cuenta_errores), 32'd1);

    // Reset with two items in flight
    listo_fixed = 1'b0;
    send_a(8'h10, 6'd10, 1'b0, 1'b0);
    send_a(8'h20, 6'd20, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst2_valido", 32'(bus_a.valido_salida), 32'd0);
    check("rst2_cuenta", 32'(bus_a.cuenta_errores), 32'd0);
    check("rst2_binario", 32'(bus_a.binario_salida), 32'd0);
    reset_n = 1'b1;
    listo_fixed = 1'b1;
    send_a(8'h45, 6'd45, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) send_a(8'hAA, 6'd0, 1'b1, 1'b0);
    drain("drain_sat");
    check("cuenta_sat", 32'(bus_a.cuenta_errores), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
